// File: rtl/muldiv_sequencer_pkg.sv
// RV64M multiply/divide types and helpers shared by the sequencer and execute stage.
// Pure declarations: no latency, no flow control.
package muldiv_sequencer_pkg;

   localparam int MDU_XLEN  = 64;
   localparam int MDU_CNT_W = 7;

   // Encoding follows funct3 so decode can pass the field straight through.
   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mdu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mdu_state_t;

   function automatic logic is_signed_a(input mdu_op_t op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(input mdu_op_t op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into rem, trial-subtract divisor.
// Combinational, zero latency; no flow control.
module mdu_div_step #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quot,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_nxt,
   output logic [XLEN-1:0] quot_nxt
);

   logic [XLEN:0] trial;
   logic [XLEN:0] diff;

   // trial < 2*divisor, so the MSB of the XLEN+1 bit difference is a clean borrow flag.
   assign trial    = {rem, quot[XLEN-1]};
   assign diff     = trial - {1'b0, divisor};
   assign rem_nxt  = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
   assign quot_nxt = {quot[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 RV64M mul/div: done N+1 cycles after start (N=64, or 32 for W ops), 1 for div-by-zero/overflow.
// No backpressure: busy holds execute; start is only sampled in IDLE/DONE and flush always wins.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int XLEN  = MDU_XLEN,
   parameter int CNT_W = MDU_CNT_W
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic            is_word,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int HALF = XLEN / 2;

   mdu_state_t        state_q, state_d;
   mdu_op_t           op_in, op_q;
   logic              word_q, neg_res_q, neg_a_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   opnd_q;

   logic              accept, sa, sb, neg_a, neg_b, div0, ovf, shortcut;
   logic [XLEN-1:0]   ext_a, ext_b, mag_a, mag_b, min_val, short_val;

   assign op_in  = mdu_op_t'(op);
   assign accept = start && !flush && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   // Operands are reduced to magnitudes up front; signs are re-applied once at the end.
   always_comb begin
      sa      = is_signed_a(op_in);
      sb      = is_signed_b(op_in);
      ext_a   = is_word ? {{HALF{sa & src_a[HALF-1]}}, src_a[HALF-1:0]} : src_a;
      ext_b   = is_word ? {{HALF{sb & src_b[HALF-1]}}, src_b[HALF-1:0]} : src_b;
      neg_a   = sa & ext_a[XLEN-1];
      neg_b   = sb & ext_b[XLEN-1];
      mag_a   = neg_a ? -ext_a : ext_a;
      mag_b   = neg_b ? -ext_b : ext_b;
      min_val = is_word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      div0    = op_in[2] && (ext_b == '0);
      ovf     = op_in[2] && sa && (ext_a == min_val) && (ext_b == '1);
      shortcut = div0 || ovf;
      if (div0)
         short_val = op_in[1] ? (is_word ? {{HALF{src_a[HALF-1]}}, src_a[HALF-1:0]} : src_a) : '1;
      else
         short_val = op_in[1] ? '0 : min_val;
   end

   // Iteration datapath: shift-add multiply inline, restoring divide in the sub-module.
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_nxt, step_nxt;
   logic [XLEN-1:0]   div_rem, div_quot;

   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
   assign step_nxt = op_q[2] ? {div_rem, div_quot} : mul_nxt;

   mdu_div_step #(.XLEN(XLEN)) u_div_step (
      .rem      (acc_q[2*XLEN-1:XLEN]),
      .quot     (acc_q[XLEN-1:0]),
      .divisor  (opnd_q),
      .rem_nxt  (div_rem),
      .quot_nxt (div_quot)
   );

   // A half-length multiply leaves its product at [XLEN+HALF-1:HALF].
   logic [2*XLEN-1:0] prod_full, prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, raw_res, fin_res;

   always_comb begin
      prod_full = word_q ? {{XLEN{1'b0}}, step_nxt[XLEN+HALF-1:HALF]} : step_nxt;
      prod_fix  = neg_res_q ? -prod_full : prod_full;
      quot_fix  = neg_res_q ? -step_nxt[XLEN-1:0] : step_nxt[XLEN-1:0];
      rem_fix   = neg_a_q ? -step_nxt[2*XLEN-1:XLEN] : step_nxt[2*XLEN-1:XLEN];
      if (op_q[2])
         raw_res = op_q[1] ? rem_fix : quot_fix;
      else
         raw_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      fin_res = word_q ? {{HALF{raw_res[HALF-1]}}, raw_res[HALF-1:0]} : raw_res;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = (state_q == ST_RUN);
      done    = (state_q == ST_DONE) && !flush;
      case (state_q)
         ST_IDLE: if (accept) state_d = shortcut ? ST_DONE : ST_RUN;
         ST_RUN:  if (cnt_q == '0) state_d = ST_DONE;
         ST_DONE: state_d = accept ? (shortcut ? ST_DONE : ST_RUN) : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (flush) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q      <= OP_MUL;
         word_q    <= 1'b0;
         neg_res_q <= 1'b0;
         neg_a_q   <= 1'b0;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         result    <= '0;
      end else if (accept) begin
         op_q      <= op_in;
         word_q    <= is_word;
         neg_res_q <= neg_a ^ neg_b;
         neg_a_q   <= neg_a;
         cnt_q     <= is_word ? CNT_W'(HALF-1) : CNT_W'(XLEN-1);
         opnd_q    <= op_in[2] ? mag_b : mag_a;
         if (op_in[2])
            acc_q <= {{XLEN{1'b0}}, (is_word ? {mag_a[HALF-1:0], {HALF{1'b0}}} : mag_a)};
         else
            acc_q <= {{XLEN{1'b0}}, mag_b};
         if (shortcut) result <= short_val;
      end else if ((state_q == ST_RUN) && !flush) begin
         acc_q <= step_nxt;
         cnt_q <= cnt_q - CNT_W'(1);
         if (cnt_q == '0) result <= fin_res;
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: latency, busy length and result per op,
// plus shortcut, back-to-back, flush and mid-op reset behaviour.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic        is_word = 1'b0;
   logic [63:0] src_a = '0;
   logic [63:0] src_b = '0;
   logic        flush = 1'b0;
   logic        busy, done;
   logic [63:0] result;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

   muldiv_sequencer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .is_word (is_word),
      .src_a   (src_a),
      .src_b   (src_b),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   // Starts one op at posedge+1, scrambles the operand inputs after acceptance,
   // then counts edges until done and the busy cycles seen on the way.
   task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input int lat_exp, input logic [63:0] res_exp, input int busy_exp);
      int lat;
      int bcnt;
      op = o; is_word = w; src_a = a; src_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      src_a = ~a;
      src_b = ~b + 64'd3;
      lat = 0;
      bcnt = 0;
      while (!done && lat < 100) begin
         if (busy) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'(lat_exp));
      check({tag, "_busy"}, 64'(bcnt), 64'(busy_exp));
      check({tag, "_res"}, result, res_exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      #2 reset_n = 1'b0;
      #10;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_result", result, 64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      run_op("mul", 3'd0, 1'b0, 64'd7, -64'd3, 64, 64'hFFFF_FFFF_FFFF_FFEB, 64);
      run_op("div", 3'd4, 1'b0, -64'd20, 64'd3, 64, -64'd6, 64);
      check("b2b_in_done", {63'd0, done}, 64'd1);
      run_op("rem", 3'd6, 1'b0, -64'd20, 64'd3, 64, -64'd2, 64);
      @(posedge clk); #1;
      check("done_pulse", {63'd0, done}, 64'd0);
      check("result_hold", result, -64'd2);

      run_op("divu_z", 3'd5, 1'b0, 64'd5, 64'd0, 0, ONES, 0);
      run_op("remu_z", 3'd7, 1'b0, 64'd5, 64'd0, 0, 64'd5, 0);
      run_op("div_ovf", 3'd4, 1'b0, MIN, ONES, 0, MIN, 0);
      run_op("rem_ovf", 3'd6, 1'b0, MIN, ONES, 0, 64'd0, 0);

      run_op("mulw", 3'd0, 1'b1, 64'h0000_0001_7FFF_FFFF, 64'd2, 32, 64'hFFFF_FFFF_FFFF_FFFE, 32);
      run_op("mulhu", 3'd3, 1'b0, ONES, ONES, 64, 64'hFFFF_FFFF_FFFF_FFFE, 64);
      run_op("mulh", 3'd1, 1'b0, ONES, ONES, 64, 64'd0, 64);
      run_op("mulhsu", 3'd2, 1'b0, ONES, 64'd2, 64, ONES, 64);
      run_op("divw", 3'd4, 1'b1, 64'h1234_5678_FFFF_FFEC, 64'd3, 32, -64'd6, 32);

      // flush and start together in DONE: flush wins, nothing accepted
      op = 3'd5; is_word = 1'b0; src_a = 64'd100; src_b = 64'd0;
      start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("flush_start_busy", {63'd0, busy}, 64'd0);
      check("flush_start_done", {63'd0, done}, 64'd0);
      check("flush_start_res", result, -64'd6);

      // flush in the tenth RUN cycle
      src_b = 64'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      check("pre_flush_busy", {63'd0, busy}, 64'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy", {63'd0, busy}, 64'd0);
      seen = 0;
      repeat (70) begin
         if (done) seen++;
         @(posedge clk); #1;
      end
      check("flush_no_done", 64'(seen), 64'd0);
      check("flush_res_hold", result, -64'd6);
      run_op("divu_after_flush", 3'd5, 1'b0, 64'd100, 64'd7, 64, 64'd14, 64);

      // asynchronous reset mid-RUN
      op = 3'd0; src_a = 64'd3; src_b = 64'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      #1;
      check("rstmid_busy", {63'd0, busy}, 64'd0);
      check("rstmid_done", {63'd0, done}, 64'd0);
      check("rstmid_result", result, 64'd0);
      #2 reset_n = 1'b1;
      @(posedge clk); #1;
      seen = 0;
      repeat (70) begin
         if (done) seen++;
         @(posedge clk); #1;
      end
      check("rstmid_no_done", 64'(seen), 64'd0);
      run_op("remu_after_rst", 3'd7, 1'b0, 64'd100, 64'd7, 64, 64'd2, 64);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
